pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage 16-bit pipeline.
- Drives write-enable, flush and Special_Change controls of the IF/ID, ID/EX, EX2MEM and MEM/WB registers.
- Resolves three hazards: load-use stalls, taken-branch flushes, and multi-cycle memory waits, including a timeout guard and a stall statistics counter.

---
 rtl/pipeline_hazard_ctrl_if.sv | 41 ++++
 rtl/pipeline_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// The slave modport is the sequencer's view; master is the datapath's view.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 4
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_flush;
    logic             ex_mem_special_change;
    logic             ex_mem_write;
    logic             mem_wb_bubble;
    logic             mem_timeout;
    logic [15:0]      stall_count;
    logic [1:0]       state_o;

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
               branch_taken, mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_special_change, ex_mem_write, mem_wb_bubble,
               mem_timeout, stall_count, state_o
    );

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
               branch_taken, mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_special_change, ex_mem_write, mem_wb_bubble,
               mem_timeout, stall_count, state_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and multi-cycle memory waits with timeout guard and stall statistics.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rest,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              mem_timeout_reg, mem_timeout_next;
    logic [15:0]       stall_count_reg;

    logic load_use;
    logic mem_stall;
    logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_write_c, id_ex_flush_c;
    logic special_c, ex_mem_write_c, bubble_c;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                      ((hz.ex_rd == hz.id_rs1) || (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));
    assign mem_stall = hz.mem_req && !hz.mem_ready;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
            if (!pc_write_c && (stall_count_reg != 16'hFFFF))
                stall_count_reg <= stall_count_reg + 16'd1;
        end
    end

    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        mem_timeout_next = mem_timeout_reg;
        case (state_reg)
            RUN: begin
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_next = CAPTURE;
                end else if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    // Abandon the access; the error flag stays set until reset.
                    state_next       = RUN;
                    mem_timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            CAPTURE:  state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_comb begin
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_write_c  = 1'b1;
        id_ex_flush_c  = 1'b0;
        special_c      = 1'b0;
        ex_mem_write_c = 1'b1;
        bubble_c       = 1'b0;
        case (state_reg)
            RUN: begin
                if (mem_stall) begin
                    pc_write_c     = 1'b0;
                    if_id_write_c  = 1'b0;
                    id_ex_write_c  = 1'b0;
                    ex_mem_write_c = 1'b0;
                    bubble_c       = 1'b1;
                end else if (hz.branch_taken) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    id_ex_flush_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                pc_write_c     = 1'b0;
                if_id_write_c  = 1'b0;
                id_ex_write_c  = 1'b0;
                ex_mem_write_c = 1'b0;
                bubble_c       = 1'b1;
            end
            CAPTURE: begin
                // Load returned data into AluOrMem while Read1/Rd are held.
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                id_ex_write_c = 1'b0;
                special_c     = 1'b1;
                bubble_c      = 1'b1;
            end
            default: ;
        endcase
        if (rest) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            if_id_flush_c  = 1'b0;
            id_ex_write_c  = 1'b0;
            id_ex_flush_c  = 1'b0;
            special_c      = 1'b0;
            ex_mem_write_c = 1'b0;
            bubble_c       = 1'b0;
        end
    end

    assign hz.pc_write              = pc_write_c;
    assign hz.if_id_write           = if_id_write_c;
    assign hz.if_id_flush           = if_id_flush_c;
    assign hz.id_ex_write           = id_ex_write_c;
    assign hz.id_ex_flush           = id_ex_flush_c;
    assign hz.ex_mem_special_change = special_c;
    assign hz.ex_mem_write          = ex_mem_write_c;
    assign hz.mem_wb_bubble         = bubble_c;
    assign hz.mem_timeout           = mem_timeout_reg;
    assign hz.stall_count           = stall_count_reg;
    assign hz.state_o               = state_reg;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rest;
    int   total;
    int   bad;

    pipeline_hazard_ctrl_if #(.REG_W(4)) hz ();

    pipeline_hazard_ctrl #(.REG_W(4), .MEM_TIMEOUT(4)) dut (
        .clk  (clk),
        .rest (rest),
        .hz   (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_idle();
        hz.id_rs1 = 4'd0; hz.id_rs2 = 4'd0; hz.id_uses_rs2 = 1'b0;
        hz.ex_mem_read = 1'b0; hz.ex_rd = 4'd0; hz.branch_taken = 1'b0;
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rest = 1'b1;
        set_idle();
        #1;
        $display("reset: pc_write=%0d state=%0d stall=%0d", hz.pc_write, hz.state_o, hz.stall_count);
        total++; if (hz.pc_write !== 1'b0) begin bad++; $display("FAIL rst_pc_write got=%0d exp=0", hz.pc_write); end
        total++; if (hz.ex_mem_write !== 1'b0) begin bad++; $display("FAIL rst_ex_mem_write got=%0d exp=0", hz.ex_mem_write); end
        total++; if (hz.state_o !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", hz.state_o); end
        total++; if (hz.stall_count !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0d exp=0", hz.stall_count); end
        tick();
        rest = 1'b0;
        #1;
        $display("run idle: pc_write=%0d if_id_write=%0d id_ex_write=%0d ex_mem_write=%0d",
                 hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write);
        total++; if ({hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write} !== 4'b1111) begin
            bad++; $display("FAIL idle_writes got=%b exp=1111", {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write}); end
        total++; if ({hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_special_change, hz.mem_wb_bubble} !== 4'b0000) begin
            bad++; $display("FAIL idle_flushes got=%b exp=0000", {hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_special_change, hz.mem_wb_bubble}); end
    endtask

    task automatic test_load_use();
        tick();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 4'd3; hz.id_rs1 = 4'd3;
        #1;
        $display("load_use rs1: pc_write=%0d if_id_write=%0d id_ex_flush=%0d", hz.pc_write, hz.if_id_write, hz.id_ex_flush);
        total++; if ({hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.id_ex_write} !== 4'b0011) begin
            bad++; $display("FAIL lu_rs1_ctrl got=%b exp=0011", {hz.pc_write, hz.if_id_write, hz.id_ex_flush, hz.id_ex_write}); end
        total++; if (hz.if_id_flush !== 1'b0) begin bad++; $display("FAIL lu_if_id_flush got=%0d exp=0", hz.if_id_flush); end
        tick();
        set_idle();
        #1;
        $display("after load_use: pc_write=%0d stall=%0d", hz.pc_write, hz.stall_count);
        total++; if (hz.stall_count !== 16'd1) begin bad++; $display("FAIL lu_stall_count got=%0d exp=1", hz.stall_count); end
        total++; if ({hz.pc_write, hz.if_id_write, hz.id_ex_flush} !== 3'b110) begin
            bad++; $display("FAIL lu_release got=%b exp=110", {hz.pc_write, hz.if_id_write, hz.id_ex_flush}); end
        hz.ex_mem_read = 1'b1; hz.ex_rd = 4'd3; hz.id_rs1 = 4'd5; hz.id_rs2 = 4'd3; hz.id_uses_rs2 = 1'b1;
        #1;
        $display("load_use rs2: pc_write=%0d id_ex_flush=%0d", hz.pc_write, hz.id_ex_flush);
        total++; if ({hz.pc_write, hz.id_ex_flush} !== 2'b01) begin
            bad++; $display("FAIL lu_rs2_ctrl got=%b exp=01", {hz.pc_write, hz.id_ex_flush}); end
        tick();
        set_idle();
        #1;
        total++; if (hz.stall_count !== 16'd2) begin bad++; $display("FAIL lu_rs2_stall got=%0d exp=2", hz.stall_count); end
    endtask

    task automatic test_no_stall();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 4'd0; hz.id_rs1 = 4'd0;
        #1;
        $display("rd0: pc_write=%0d id_ex_flush=%0d", hz.pc_write, hz.id_ex_flush);
        total++; if ({hz.pc_write, hz.id_ex_flush} !== 2'b10) begin
            bad++; $display("FAIL rd0_no_stall got=%b exp=10", {hz.pc_write, hz.id_ex_flush}); end
        hz.ex_rd = 4'd3; hz.id_rs1 = 4'd5; hz.id_rs2 = 4'd3; hz.id_uses_rs2 = 1'b0;
        #1;
        $display("rs2 unused: pc_write=%0d id_ex_flush=%0d", hz.pc_write, hz.id_ex_flush);
        total++; if ({hz.pc_write, hz.id_ex_flush} !== 2'b10) begin
            bad++; $display("FAIL rs2_unused_no_stall got=%b exp=10", {hz.pc_write, hz.id_ex_flush}); end
        hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
        #1;
        total++; if ({hz.pc_write, hz.ex_mem_write, hz.mem_wb_bubble} !== 3'b110) begin
            bad++; $display("FAIL mem_ready_run got=%b exp=110", {hz.pc_write, hz.ex_mem_write, hz.mem_wb_bubble}); end
        tick();
        set_idle();
        #1;
        total++; if (hz.stall_count !== 16'd2 || hz.state_o !== 2'd0) begin
            bad++; $display("FAIL no_stall_count got=%0d/%0d exp=2/0", hz.stall_count, hz.state_o); end
    endtask

    task automatic test_branch();
        hz.branch_taken = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_rd = 4'd3; hz.id_rs1 = 4'd3;
        #1;
        $display("branch+load_use: if_id_flush=%0d id_ex_flush=%0d pc_write=%0d", hz.if_id_flush, hz.id_ex_flush, hz.pc_write);
        total++; if ({hz.if_id_flush, hz.id_ex_flush, hz.pc_write, hz.if_id_write} !== 4'b1111) begin
            bad++; $display("FAIL branch_ctrl got=%b exp=1111", {hz.if_id_flush, hz.id_ex_flush, hz.pc_write, hz.if_id_write}); end
        tick();
        set_idle();
        #1;
        total++; if (hz.stall_count !== 16'd2) begin bad++; $display("FAIL branch_stall got=%0d exp=2", hz.stall_count); end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_state;
            exp_state = (i == 0 || i == 5) ? 2'd0 : ((i == 4) ? 2'd2 : 2'd1);
            hz.mem_req = (i < 4); hz.mem_ready = (i == 3);
            hz.branch_taken = (i == 0);
            #1;
            $display("mem_wait cyc%0d: state=%0d pc_write=%0d special=%0d ex_mem_write=%0d stall=%0d",
                     i, hz.state_o, hz.pc_write, hz.ex_mem_special_change, hz.ex_mem_write, hz.stall_count);
            total++; if (hz.state_o !== exp_state) begin bad++; $display("FAIL mw_state cyc%0d got=%0d exp=%0d", i, hz.state_o, exp_state); end
            total++; if (hz.pc_write !== (i >= 5)) begin bad++; $display("FAIL mw_pc_write cyc%0d got=%0d exp=%0d", i, hz.pc_write, i >= 5); end
            total++; if (hz.ex_mem_special_change !== (i == 4)) begin
                bad++; $display("FAIL mw_special cyc%0d got=%0d exp=%0d", i, hz.ex_mem_special_change, i == 4); end
            total++; if (hz.ex_mem_write !== (i >= 4)) begin bad++; $display("FAIL mw_ex_mem_write cyc%0d got=%0d exp=%0d", i, hz.ex_mem_write, i >= 4); end
            total++; if (hz.mem_wb_bubble !== (i < 5)) begin bad++; $display("FAIL mw_bubble cyc%0d got=%0d exp=%0d", i, hz.mem_wb_bubble, i < 5); end
            total++; if (hz.if_id_flush !== 1'b0) begin bad++; $display("FAIL mw_branch_ignored cyc%0d got=%0d exp=0", i, hz.if_id_flush); end
            total++; if (hz.stall_count !== 16'(2 + i)) begin bad++; $display("FAIL mw_stall cyc%0d got=%0d exp=%0d", i, hz.stall_count, 2 + i); end
            tick();
        end
        set_idle();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_state;
            exp_state = (i >= 1 && i <= 3) ? 2'd1 : 2'd0;
            hz.mem_req = (i < 4); hz.mem_ready = 1'b0;
            #1;
            $display("timeout cyc%0d: state=%0d mem_timeout=%0d stall=%0d", i, hz.state_o, hz.mem_timeout, hz.stall_count);
            total++; if (hz.state_o !== exp_state) begin bad++; $display("FAIL to_state cyc%0d got=%0d exp=%0d", i, hz.state_o, exp_state); end
            total++; if (hz.mem_timeout !== (i >= 4)) begin bad++; $display("FAIL to_flag cyc%0d got=%0d exp=%0d", i, hz.mem_timeout, i >= 4); end
            total++; if (hz.pc_write !== (i >= 4)) begin bad++; $display("FAIL to_pc_write cyc%0d got=%0d exp=%0d", i, hz.pc_write, i >= 4); end
            total++; if (hz.stall_count !== 16'(7 + ((i < 4) ? i : 4))) begin
                bad++; $display("FAIL to_stall cyc%0d got=%0d exp=%0d", i, hz.stall_count, 7 + ((i < 4) ? i : 4)); end
            tick();
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        tick();
        total++; if (hz.state_o !== 2'd1) begin bad++; $display("FAIL ar_enter_wait got=%0d exp=1", hz.state_o); end
        #2;
        rest = 1'b1; hz.mem_ready = 1'b1;
        #1;
        $display("async reset: state=%0d stall=%0d timeout=%0d pc_write=%0d bubble=%0d",
                 hz.state_o, hz.stall_count, hz.mem_timeout, hz.pc_write, hz.mem_wb_bubble);
        total++; if (hz.state_o !== 2'd0) begin bad++; $display("FAIL ar_state got=%0d exp=0", hz.state_o); end
        total++; if (hz.stall_count !== 16'd0) begin bad++; $display("FAIL ar_stall got=%0d exp=0", hz.stall_count); end
        total++; if (hz.mem_timeout !== 1'b0) begin bad++; $display("FAIL ar_timeout got=%0d exp=0", hz.mem_timeout); end
        total++; if ({hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write, hz.mem_wb_bubble, hz.ex_mem_special_change} !== 6'b0) begin
            bad++; $display("FAIL ar_outputs got=%b exp=000000",
                            {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write, hz.mem_wb_bubble, hz.ex_mem_special_change}); end
        #1;
        rest = 1'b0;
        set_idle();
        tick();
        $display("after async reset: state=%0d special=%0d pc_write=%0d stall=%0d",
                 hz.state_o, hz.ex_mem_special_change, hz.pc_write, hz.stall_count);
        total++; if (hz.state_o !== 2'd0 || hz.ex_mem_special_change !== 1'b0) begin
            bad++; $display("FAIL ar_no_capture got=%0d/%0d exp=0/0", hz.state_o, hz.ex_mem_special_change); end
        total++; if (hz.pc_write !== 1'b1 || hz.stall_count !== 16'd0) begin
            bad++; $display("FAIL ar_resume got=%0d/%0d exp=1/0", hz.pc_write, hz.stall_count); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
